// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes,
// FSM encoding and requester identifiers.
package mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: store lane mask and data replication, load lane
// extraction with extension, and funct3/alignment legality.
module mem_lane_fmt
    import mem_ctrl_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        legal
);

    logic [31:0] shifted;

    assign shifted = rdata >> {byte_off, 3'b000};

    always_comb begin
        lane_mask = 4'b0000;
        wdata_rep = wdata;
        load_data = 32'd0;
        legal     = 1'b0;
        case (funct3)
            F3_B: begin
                lane_mask = 4'b0001 << byte_off;
                wdata_rep = {4{wdata[7:0]}};
                load_data = {{24{shifted[7]}}, shifted[7:0]};
                legal     = 1'b1;
            end
            F3_H: begin
                lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                load_data = {{16{shifted[15]}}, shifted[15:0]};
                legal     = ~byte_off[0];
            end
            F3_W: begin
                lane_mask = 4'b1111;
                load_data = shifted;
                legal     = (byte_off == 2'b00);
            end
            // Unsigned variants exist only for loads.
            F3_BU: begin
                load_data = {24'd0, shifted[7:0]};
                legal     = ~we;
            end
            F3_HU: begin
                load_data = {16'd0, shifted[15:0]};
                legal     = ~we & ~byte_off[0];
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one data BRAM between
// the core load/store unit (requester 0) and the debug/DMA loader (requester 1).
module data_mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [5:0]        req_funct3,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic [1:0]        rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t      state_reg, state_next;
    logic        last_grant_reg;
    logic        gnt_reg;
    logic        we_reg;
    logic [2:0]  f3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        legal_reg;

    logic        any_valid;
    logic        gnt_sel;
    logic        in_idle;
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  lane_mask;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;
    logic        fmt_legal;
    logic        sel_legal;
    logic [1:0]  gnt_onehot;

    always_comb begin
        any_valid = |req_valid;
        gnt_sel   = REQ_CORE;
        if (req_valid == 2'b10)
            gnt_sel = REQ_DBG;
        else if (req_valid == 2'b11)
            gnt_sel = ~last_grant_reg;
    end

    assign in_idle   = (state_reg == S_IDLE);
    assign req_ready = (in_idle && any_valid) ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;

    // In IDLE the formatter sees the incoming request so the BRAM strobes can
    // be registered on the accepting edge; afterwards it sees the latched copy.
    assign sel_we    = in_idle ? req_we[gnt_sel] : we_reg;
    assign sel_f3    = in_idle ? (gnt_sel ? req_funct3[5:3] : req_funct3[2:0]) : f3_reg;
    assign sel_addr  = in_idle ? (gnt_sel ? req_addr[63:32] : req_addr[31:0]) : addr_reg;
    assign sel_wdata = in_idle ? (gnt_sel ? req_wdata[63:32] : req_wdata[31:0]) : wdata_reg;
    assign sel_legal = fmt_legal && (sel_addr[31:ADDR_W+2] == '0);
    assign gnt_onehot = gnt_reg ? 2'b10 : 2'b01;

    mem_lane_fmt u_fmt (
        .we        (sel_we),
        .funct3    (sel_f3),
        .byte_off  (sel_addr[1:0]),
        .wdata     (sel_wdata),
        .rdata     (ram_rdata),
        .lane_mask (lane_mask),
        .wdata_rep (wdata_rep),
        .load_data (load_data),
        .legal     (fmt_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (any_valid) state_next = S_ACCESS;
            S_ACCESS: state_next = (!legal_reg || we_reg) ? S_RESP : S_WAIT;
            S_WAIT:   state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            gnt_reg        <= 1'b0;
            we_reg         <= 1'b0;
            f3_reg         <= 3'd0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            legal_reg      <= 1'b0;
            rsp_valid      <= 2'b00;
            rsp_rdata      <= 32'd0;
            rsp_err        <= 1'b0;
            ram_en         <= 1'b0;
            ram_we         <= 4'd0;
            ram_addr       <= '0;
            ram_wdata      <= 32'd0;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 4'd0;
            rsp_valid <= 2'b00;
            case (state_reg)
                S_IDLE: begin
                    if (any_valid) begin
                        gnt_reg        <= gnt_sel;
                        last_grant_reg <= gnt_sel;
                        we_reg         <= sel_we;
                        f3_reg         <= sel_f3;
                        addr_reg       <= sel_addr;
                        wdata_reg      <= sel_wdata;
                        legal_reg      <= sel_legal;
                        ram_en         <= sel_legal;
                        ram_we         <= (sel_legal && sel_we) ? lane_mask : 4'd0;
                        ram_addr       <= sel_addr[ADDR_W+1:2];
                        ram_wdata      <= wdata_rep;
                    end
                end
                S_ACCESS: begin
                    if (!legal_reg || we_reg) begin
                        rsp_valid <= gnt_onehot;
                        rsp_err   <= ~legal_reg;
                        rsp_rdata <= 32'd0;
                    end
                end
                S_WAIT: begin
                    rsp_valid <= gnt_onehot;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= load_data;
                end
                default: rsp_err <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 1-cycle-latency
// byte-write BRAM attached to the memory port.
module tb_data_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [5:0]        req_funct3;
    logic [63:0]       req_addr;
    logic [63:0]       req_wdata;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int n_err = 0;
    int n_chk = 0;

    logic        obs_en;
    logic [3:0]  obs_we;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [1:0]  obs_valid;
    logic [1:0]  obs_valid_after;
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_lat;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request from requester id; called at posedge+1.
    task automatic do_req(input int id, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int n;
        req_valid = 2'b00;
        req_we[id] = we;
        req_funct3[3*id +: 3] = f3;
        req_addr[32*id +: 32] = addr;
        req_wdata[32*id +: 32] = wd;
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready", {30'd0, req_ready}, (id == 1) ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_addr  = {2{32'hFFFF_FFFF}};
        req_wdata = {2{32'h1234_5678}};
        obs_en    = ram_en;
        obs_we    = ram_we;
        obs_addr  = {{(32-ADDR_W){1'b0}}, ram_addr};
        obs_wdata = ram_wdata;
        obs_lat   = 1;
        while (rsp_valid == 2'b00 && obs_lat < 8) begin
            @(posedge clk); #1;
            obs_lat++;
        end
        obs_valid = rsp_valid;
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
        @(posedge clk); #1;
        obs_valid_after = rsp_valid;
    endtask

    task automatic chk_rsp(input string tag, input int id, input int lat,
                           input logic err, input logic [31:0] rdata);
        $display("txn %s: req%0d lat=%0d valid=%b err=%b rdata=%h", tag, id,
                 obs_lat, obs_valid, obs_err, obs_rdata);
        chk({tag, "_lat"},   obs_lat, lat);
        chk({tag, "_valid"}, {30'd0, obs_valid}, (id == 1) ? 32'd2 : 32'd1);
        chk({tag, "_err"},   {31'd0, obs_err}, {31'd0, err});
        chk({tag, "_rdata"}, obs_rdata, rdata);
        chk({tag, "_pulse"}, {30'd0, obs_valid_after}, 32'd0);
    endtask

    task automatic chk_ram(input string tag, input logic en, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wd);
        chk({tag, "_ram_en"}, {31'd0, obs_en}, {31'd0, en});
        chk({tag, "_ram_we"}, {28'd0, obs_we}, {28'd0, we});
        if (en) begin
            chk({tag, "_ram_addr"}, obs_addr, addr);
            if (we != 4'd0) chk({tag, "_ram_wdata"}, obs_wdata, wd);
        end
    endtask

    initial begin
        int gcount;
        int n;
        logic [1:0] seen;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_we     = 2'b00;
        req_funct3 = 6'd0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_outs", {25'd0, rsp_err, ram_en, ram_we, 1'b0}, 32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk_ram("sw", 1'b1, 4'b1111, 32'd4, 32'hDEADBEEF);
        chk_rsp("sw", 0, 2, 1'b0, 32'd0);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'd0);
        chk_ram("lw", 1'b1, 4'b0000, 32'd4, 32'd0);
        chk_rsp("lw", 0, 3, 1'b0, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'b000, 32'h13, 32'd0);
        chk_rsp("lb", 0, 3, 1'b0, 32'hFFFFFFDE);
        do_req(1, 1'b0, 3'b100, 32'h13, 32'd0);
        chk_rsp("lbu", 1, 3, 1'b0, 32'h000000DE);
        do_req(0, 1'b0, 3'b001, 32'h12, 32'd0);
        chk_rsp("lh", 0, 3, 1'b0, 32'hFFFFDEAD);
        do_req(0, 1'b0, 3'b101, 32'h10, 32'd0);
        chk_rsp("lhu", 0, 3, 1'b0, 32'h0000BEEF);

        do_req(1, 1'b1, 3'b000, 32'h11, 32'h000000AA);
        chk_ram("sb", 1'b1, 4'b0010, 32'd4, 32'hAAAAAAAA);
        chk_rsp("sb", 1, 2, 1'b0, 32'd0);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'd0);
        chk_rsp("lw2", 0, 3, 1'b0, 32'hDEADAAEF);
        do_req(1, 1'b0, 3'b001, 32'h10, 32'd0);
        chk_rsp("lh2", 1, 3, 1'b0, 32'hFFFFAAEF);
        do_req(0, 1'b1, 3'b001, 32'h12, 32'h00001234);
        chk_ram("sh", 1'b1, 4'b1100, 32'd4, 32'h12341234);
        chk_rsp("sh", 0, 2, 1'b0, 32'd0);

        do_req(0, 1'b0, 3'b010, 32'h12, 32'd0);
        chk_ram("lw_mis", 1'b0, 4'b0000, 32'd0, 32'd0);
        chk_rsp("lw_mis", 0, 2, 1'b1, 32'd0);
        do_req(0, 1'b1, 3'b001, 32'h01, 32'hFFFF);
        chk_ram("sh_mis", 1'b0, 4'b0000, 32'd0, 32'd0);
        chk_rsp("sh_mis", 0, 2, 1'b1, 32'd0);
        do_req(0, 1'b1, 3'b100, 32'h10, 32'hFF);
        chk_ram("sbu_bad", 1'b0, 4'b0000, 32'd0, 32'd0);
        chk_rsp("sbu_bad", 0, 2, 1'b1, 32'd0);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'd0);
        chk_rsp("lw3", 0, 3, 1'b0, 32'h1234AAEF);
        do_req(1, 1'b0, 3'b010, 32'h1000, 32'd0);
        chk_ram("lw_oor", 1'b0, 4'b0000, 32'd0, 32'd0);
        chk_rsp("lw_oor", 1, 2, 1'b1, 32'd0);

        // Both requesters held valid; last grant was requester 1.
        req_we     = 2'b11;
        req_funct3 = {3'b010, 3'b010};
        req_addr   = {32'h24, 32'h20};
        req_wdata  = {32'h22222222, 32'h11111111};
        req_valid  = 2'b11;
        for (gcount = 0; gcount < 4; gcount++) begin
            n = 0;
            #1;
            while (req_ready == 2'b00 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            seen = req_ready;
            $display("txn arb%0d: ready=%b", gcount, seen);
            chk("arb_grant", {30'd0, seen}, (gcount % 2 == 1) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            n = 0;
            while (rsp_valid == 2'b00 && n < 8) begin
                @(posedge clk); #1;
                n++;
            end
            chk("arb_rsp_valid", {30'd0, rsp_valid}, {30'd0, seen});
            @(posedge clk);
        end
        #1;
        req_valid = 2'b00;
        chk("arb_mem0", mem[8], 32'h11111111);
        chk("arb_mem1", mem[9], 32'h22222222);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset during the WAIT cycle of a load from requester 0.
        req_we[0] = 1'b0;
        req_funct3[2:0] = 3'b010;
        req_addr[31:0] = 32'h10;
        req_wdata[31:0] = 32'h55555555;
        req_valid = 2'b01;
        #1;
        chk("mid_ready", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        $display("txn mid_rst: rsp_valid=%b rdata=%h ram_en=%b", rsp_valid, rsp_rdata, ram_en);
        chk("mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("mid_rsp_rdata", rsp_rdata, 32'd0);
        chk("mid_outs", {26'd0, rsp_err, ram_en, ram_we}, 32'd0);
        chk("mid_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("mid_ram_wdata", ram_wdata, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("mid_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
